// File: rtl/adder_share_pkg.sv
// Shared types and helpers for the round-robin shared adder.
// Provides the arbiter state enum, the round-robin pick function and the ID width helper.
package adder_share_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    // Index width: at least one bit even when there are two requesters.
    function automatic int id_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

    // First valid index at or after ptr, wrapping modulo n.
    // The loop runs downward so the smallest offset from ptr is the one kept.
    function automatic int rr_pick(input logic [15:0] valid,
                                   input int ptr,
                                   input int n);
        int g;
        int idx;
        g = ptr;
        for (int k = 15; k >= 0; k--) begin
            if (k < n) begin
                idx = (ptr + k) % n;
                if (valid[idx]) g = idx;
            end
        end
        return g;
    endfunction

endpackage

// File: rtl/adder_share_dp.sv
// Combinational WIDTH-bit adder shared by all requesters.
// Ports: a_i, b_i, cin_i in; sum_o (WIDTH bits) and cout_o (true carry out of the MSB) out.
module adder_share_dp #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o
);

    assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {{WIDTH{1'b0}}, cin_i};

endmodule

// File: rtl/adder_share_arb.sv
// Round-robin arbiter sharing one adder between NUM_REQ requesters, with carry-chained bursts.
// Ports: clk, rst (sync, active-high); per-requester req_valid/ready/a/b/cin/last;
// registered response rsp_valid/ready/sum/cout/id/last. Optional ADDER_SHARE_ARB_OVF_EN adds rsp_ovf.
module adder_share_arb
    import adder_share_pkg::*;
#(
    parameter  int WIDTH   = 32,
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = id_width(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    input  logic [NUM_REQ-1:0]       req_cin,
    input  logic [NUM_REQ-1:0]       req_last,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [WIDTH-1:0]         rsp_sum,
    output logic                     rsp_cout,
    output logic [ID_W-1:0]          rsp_id,
`ifdef ADDER_SHARE_ARB_OVF_EN
    output logic                     rsp_ovf,
`endif
    output logic                     rsp_last
);

    arb_state_t       state_q, state_d;
    logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]  owner_q, owner_d;
    logic             carry_q, carry_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0] rsp_sum_q, rsp_sum_d;
    logic             rsp_cout_q, rsp_cout_d;
    logic [ID_W-1:0]  rsp_id_q, rsp_id_d;
    logic             rsp_last_q, rsp_last_d;

    logic [ID_W-1:0]  gnt;
    logic             slot_free;
    logic             accept;
    logic [WIDTH-1:0] op_a, op_b, dp_sum;
    logic             op_cin, dp_cout;

    // In a burst the owner is the only candidate; otherwise the round-robin pick.
    always_comb begin
        if (state_q == BURST) gnt = owner_q;
        else gnt = ID_W'(rr_pick(16'(req_valid), int'(rr_ptr_q), NUM_REQ));
    end

    assign slot_free = !rsp_valid_q || rsp_ready;
    assign op_a      = req_a[int'(gnt)*WIDTH +: WIDTH];
    assign op_b      = req_b[int'(gnt)*WIDTH +: WIDTH];
    assign op_cin    = (state_q == BURST) ? carry_q : req_cin[gnt];

    adder_share_dp #(.WIDTH(WIDTH)) u_dp (
        .a_i    (op_a),
        .b_i    (op_b),
        .cin_i  (op_cin),
        .sum_o  (dp_sum),
        .cout_o (dp_cout)
    );

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        owner_d     = owner_q;
        carry_d     = carry_q;
        rsp_valid_d = rsp_valid_q;
        rsp_sum_d   = rsp_sum_q;
        rsp_cout_d  = rsp_cout_q;
        rsp_id_d    = rsp_id_q;
        rsp_last_d  = rsp_last_q;
        req_ready   = '0;
        accept      = 1'b0;

        if (!rst && slot_free && req_valid[gnt]) begin
            req_ready[gnt] = 1'b1;
            accept         = 1'b1;
        end

        if (accept) begin
            rsp_valid_d = 1'b1;
            rsp_sum_d   = dp_sum;
            rsp_cout_d  = dp_cout;
            rsp_id_d    = gnt;
            rsp_last_d  = req_last[gnt];
            carry_d     = dp_cout;
            if (req_last[gnt]) begin
                state_d  = IDLE;
                rr_ptr_d = (gnt == ID_W'(NUM_REQ - 1)) ? '0 : gnt + ID_W'(1);
            end else begin
                state_d = BURST;
                owner_d = gnt;
            end
        end else if (rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            owner_q     <= '0;
            carry_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_sum_q   <= '0;
            rsp_cout_q  <= 1'b0;
            rsp_id_q    <= '0;
            rsp_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            owner_q     <= owner_d;
            carry_q     <= carry_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_sum_q   <= rsp_sum_d;
            rsp_cout_q  <= rsp_cout_d;
            rsp_id_q    <= rsp_id_d;
            rsp_last_q  <= rsp_last_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_sum   = rsp_sum_q;
    assign rsp_cout  = rsp_cout_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_last  = rsp_last_q;

`ifdef ADDER_SHARE_ARB_OVF_EN
    logic rsp_ovf_q;
    logic beat_ovf;

    // Signed overflow: operands agree in sign and the result does not.
    assign beat_ovf = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (dp_sum[WIDTH-1] != op_a[WIDTH-1]);

    always_ff @(posedge clk) begin
        if (rst) rsp_ovf_q <= 1'b0;
        else if (accept) rsp_ovf_q <= beat_ovf;
    end

    assign rsp_ovf = rsp_ovf_q;
`endif

endmodule

// File: tb/tb_adder_share_arb.sv
// Directed self-checking bench for adder_share_arb (NUM_REQ=4, WIDTH=32).
// Covers round-robin order, carry-chained bursts, backpressure, wrap, owner stall and reset mid-burst.
module tb_adder_share_arb;

    localparam int W = 32;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic [N-1:0]   req_cin;
    logic [N-1:0]   req_last;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [W-1:0]   rsp_sum;
    logic           rsp_cout;
    logic [1:0]     rsp_id;
    logic           rsp_last;
`ifdef ADDER_SHARE_ARB_OVF_EN
    logic           rsp_ovf;
`endif

    int tests = 0;
    int fails = 0;

    adder_share_arb #(.WIDTH(W), .NUM_REQ(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_cin   (req_cin),
        .req_last  (req_last),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout),
        .rsp_id    (rsp_id),
`ifdef ADDER_SHARE_ARB_OVF_EN
        .rsp_ovf   (rsp_ovf),
`endif
        .rsp_last  (rsp_last)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic c, input logic l);
        req_valid[i]       = v;
        req_a[i*W +: W]    = a;
        req_b[i*W +: W]    = b;
        req_cin[i]         = c;
        req_last[i]        = l;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rsp_ready = 1'b1;
        req_a = '0; req_b = '0; req_cin = '0; req_last = '0;
        req_valid = 4'b1111;
        tick();
        tick();
        tests++; if (req_ready !== 4'b0000) begin fails++; $display("FAIL reset_ready got %b want 0000", req_ready); end
        tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", rsp_valid); end
        tests++; if ({rsp_sum, rsp_cout, rsp_id, rsp_last} !== '0) begin fails++; $display("FAIL reset_fields got %h/%b/%0d/%b want 0", rsp_sum, rsp_cout, rsp_id, rsp_last); end
        req_valid = '0;
        rst = 1'b0;
    endtask

    task automatic test_round_robin();
        int exp_g [5] = '{0, 1, 2, 3, 0};
        for (int i = 0; i < N; i++) set_req(i, 1'b1, W'(32'h10 * (i + 1)), W'(i), 1'b0, 1'b1);
        #1;
        for (int k = 0; k < 5; k++) begin
            tests++; if (req_ready !== 4'(1 << exp_g[k])) begin fails++; $display("FAIL rr_ready[%0d] got %b want %b", k, req_ready, 4'(1 << exp_g[k])); end
            tick();
            tests++; if (rsp_valid !== 1'b1 || rsp_id !== 2'(exp_g[k])) begin fails++; $display("FAIL rr_rsp[%0d] got v=%b id=%0d want v=1 id=%0d", k, rsp_valid, rsp_id, exp_g[k]); end
            tests++; if (rsp_sum !== W'(32'h10 * (exp_g[k] + 1) + exp_g[k])) begin fails++; $display("FAIL rr_sum[%0d] got %h want %h", k, rsp_sum, W'(32'h10 * (exp_g[k] + 1) + exp_g[k])); end
        end
        req_valid = '0;
        tick();
        tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL rr_drain got %b want 0", rsp_valid); end
    endtask

    task automatic test_burst();
        set_req(1, 1'b1, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0);
        set_req(2, 1'b1, 32'h3, 32'h4, 1'b0, 1'b1);
        #1;
        tests++; if (req_ready !== 4'b0010) begin fails++; $display("FAIL burst_ready0 got %b want 0010", req_ready); end
        tick();
        tests++; if ({rsp_cout, rsp_sum} !== {1'b1, 32'h0} || rsp_id !== 2'd1 || rsp_last !== 1'b0) begin fails++; $display("FAIL burst_beat0 got %b_%h id=%0d last=%b want 1_00000000 id=1 last=0", rsp_cout, rsp_sum, rsp_id, rsp_last); end
        set_req(1, 1'b1, 32'h0, 32'h0, 1'b0, 1'b1);
        #1;
        tests++; if (req_ready !== 4'b0010) begin fails++; $display("FAIL burst_ready1 got %b want 0010", req_ready); end
        tick();
        tests++; if ({rsp_cout, rsp_sum} !== {1'b0, 32'h1} || rsp_last !== 1'b1) begin fails++; $display("FAIL burst_beat1 got %b_%h last=%b want 0_00000001 last=1", rsp_cout, rsp_sum, rsp_last); end
        tests++; if (req_ready !== 4'b0100) begin fails++; $display("FAIL burst_next got %b want 0100", req_ready); end
        req_valid[1] = 1'b0;
        tick();
        tests++; if (rsp_sum !== 32'h7 || rsp_id !== 2'd2) begin fails++; $display("FAIL burst_req2 got %h id=%0d want 00000007 id=2", rsp_sum, rsp_id); end
        req_valid = '0;
        tick();
    endtask

    task automatic test_backpressure();
        set_req(3, 1'b1, 32'h5, 32'h7, 1'b0, 1'b1);
        #1;
        tests++; if (req_ready !== 4'b1000) begin fails++; $display("FAIL bp_ready got %b want 1000", req_ready); end
        tick();
        req_valid[3] = 1'b0;
        set_req(0, 1'b1, 32'h1, 32'h1, 1'b0, 1'b1);
        rsp_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            tests++; if (req_ready !== 4'b0000 || rsp_valid !== 1'b1 || rsp_sum !== 32'd12 || rsp_id !== 2'd3) begin fails++; $display("FAIL bp_hold[%0d] got rdy=%b v=%b sum=%h id=%0d want 0000/1/0000000c/3", k, req_ready, rsp_valid, rsp_sum, rsp_id); end
            tick();
        end
        rsp_ready = 1'b1;
        #1;
        tests++; if (req_ready !== 4'b0001) begin fails++; $display("FAIL bp_resume got %b want 0001", req_ready); end
        tick();
        tests++; if (rsp_sum !== 32'h2 || rsp_id !== 2'd0) begin fails++; $display("FAIL bp_after got %h id=%0d want 00000002 id=0", rsp_sum, rsp_id); end
        req_valid = '0;
        tick();
    endtask

    task automatic test_wrap();
        set_req(0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1);
        tick();
        tests++; if ({rsp_cout, rsp_sum} !== {1'b1, 32'hFFFF_FFFF}) begin fails++; $display("FAIL wrap_sum got %b_%h want 1_ffffffff", rsp_cout, rsp_sum); end
`ifdef ADDER_SHARE_ARB_OVF_EN
        tests++; if (rsp_ovf !== 1'b0) begin fails++; $display("FAIL wrap_ovf0 got %b want 0", rsp_ovf); end
        req_valid[0] = 1'b0;
        set_req(1, 1'b1, 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b1);
        tick();
        tests++; if (rsp_ovf !== 1'b1 || rsp_sum !== 32'h8000_0000) begin fails++; $display("FAIL wrap_ovf1 got ovf=%b sum=%h want 1/80000000", rsp_ovf, rsp_sum); end
`endif
        req_valid = '0;
        tick();
    endtask

    task automatic test_owner_stall();
        set_req(2, 1'b1, 32'hFFFF_FFFF, 32'h2, 1'b0, 1'b0);
        #1;
        tests++; if (req_ready !== 4'b0100) begin fails++; $display("FAIL stall_start got %b want 0100", req_ready); end
        tick();
        tests++; if ({rsp_cout, rsp_sum} !== {1'b1, 32'h1}) begin fails++; $display("FAIL stall_beat0 got %b_%h want 1_00000001", rsp_cout, rsp_sum); end
        req_valid[2] = 1'b0;
        set_req(0, 1'b1, 32'h1, 32'h1, 1'b0, 1'b1);
        set_req(1, 1'b1, 32'h1, 32'h1, 1'b0, 1'b1);
        set_req(3, 1'b1, 32'h1, 32'h1, 1'b0, 1'b1);
        for (int k = 0; k < 5; k++) begin
            #1;
            tests++; if (req_ready !== 4'b0000) begin fails++; $display("FAIL stall_lock[%0d] got %b want 0000", k, req_ready); end
            tick();
        end
        tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL stall_idle got %b want 0", rsp_valid); end
        set_req(2, 1'b1, 32'h0, 32'h0, 1'b0, 1'b1);
        #1;
        tests++; if (req_ready !== 4'b0100) begin fails++; $display("FAIL stall_resume got %b want 0100", req_ready); end
        tick();
        tests++; if ({rsp_cout, rsp_sum} !== {1'b0, 32'h1} || rsp_id !== 2'd2) begin fails++; $display("FAIL stall_chain got %b_%h id=%0d want 0_00000001 id=2", rsp_cout, rsp_sum, rsp_id); end
        tests++; if (req_ready !== 4'b1000) begin fails++; $display("FAIL stall_next got %b want 1000", req_ready); end
        req_valid = '0;
        tick();
    endtask

    task automatic test_reset_mid_burst();
        set_req(3, 1'b1, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0);
        #1;
        tests++; if (req_ready !== 4'b1000) begin fails++; $display("FAIL rmb_start got %b want 1000", req_ready); end
        tick();
        tests++; if (rsp_cout !== 1'b1 || rsp_id !== 2'd3) begin fails++; $display("FAIL rmb_beat0 got cout=%b id=%0d want 1/3", rsp_cout, rsp_id); end
        set_req(0, 1'b1, 32'd10, 32'd20, 1'b1, 1'b1);
        rsp_ready = 1'b0;
        rst = 1'b1;
        #1;
        tests++; if (req_ready !== 4'b0000) begin fails++; $display("FAIL rmb_rst_ready got %b want 0000", req_ready); end
        tick();
        tests++; if (rsp_valid !== 1'b0 || rsp_sum !== 32'h0) begin fails++; $display("FAIL rmb_drop got v=%b sum=%h want 0/00000000", rsp_valid, rsp_sum); end
        rst = 1'b0;
        rsp_ready = 1'b1;
        #1;
        tests++; if (req_ready !== 4'b0001) begin fails++; $display("FAIL rmb_first got %b want 0001", req_ready); end
        tick();
        tests++; if ({rsp_cout, rsp_sum} !== {1'b0, 32'd31} || rsp_id !== 2'd0) begin fails++; $display("FAIL rmb_req0 got %b_%h id=%0d want 0_0000001f id=0", rsp_cout, rsp_sum, rsp_id); end
        req_valid[0] = 1'b0;
        set_req(3, 1'b1, 32'd5, 32'd6, 1'b0, 1'b1);
        #1;
        tests++; if (req_ready !== 4'b1000) begin fails++; $display("FAIL rmb_req3_ready got %b want 1000", req_ready); end
        tick();
        tests++; if (rsp_sum !== 32'd11 || rsp_id !== 2'd3 || rsp_last !== 1'b1) begin fails++; $display("FAIL rmb_req3 got %h id=%0d last=%b want 0000000b id=3 last=1", rsp_sum, rsp_id, rsp_last); end
        req_valid = '0;
        tick();
        tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL rmb_end got %b want 0", rsp_valid); end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_burst();
        test_backpressure();
        test_wrap();
        test_owner_stall();
        test_reset_mid_burst();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/adder_share_arb.md
Name: adder_share_arb

Overview:
- Shares one WIDTH-bit ripple adder datapath between NUM_REQ requesters using round-robin arbitration.
- Supports multi-word (multi-precision) bursts: a granted requester keeps the adder until it sends a beat with last=1, and the carry-out of each beat chains into the next.
- Sits between client engines and the adder; one registered response stage with valid/ready backpressure.

Parameters:
- WIDTH, 32, operand/sum width per beat.
- NUM_REQ, 4, number of requesters (2..16).
- ID_W, localparam = max(1, clog2(NUM_REQ)), width of the requester index.

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester beat valid.
- req_ready  out  NUM_REQ  per-requester beat accepted; one-hot or zero.
- req_a  in  NUM_REQ*WIDTH  operand A; requester i uses slice [i*WIDTH +: WIDTH].
- req_b  in  NUM_REQ*WIDTH  operand B; same slicing as req_a.
- req_cin  in  NUM_REQ  carry-in; used on the first beat of a burst only.
- req_last  in  NUM_REQ  marks the final beat of a burst.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumer ready.
- rsp_sum  out  WIDTH  sum of the accepted beat.
- rsp_cout  out  1  carry out of bit WIDTH-1.
- rsp_id  out  ID_W  index of the requester that owns the response.
- rsp_last  out  1  copy of req_last of the accepted beat.

Behaviour:
- **Reset values:**
  - rsp_valid=0; rsp_sum, rsp_cout, rsp_id, rsp_last all 0.
  - State=IDLE, rr_ptr=0, chain carry=0.
  - req_ready=0 while rst=1.
- **Slot free:** slot_free = !rsp_valid | rsp_ready.
- **State IDLE:**
  - If slot_free and any req_valid, grant the first valid index at or after rr_ptr, wrapping modulo NUM_REQ.
  - req_ready[grant]=1 in the same cycle (combinational from req_valid, state, rr_ptr, slot_free).
  - Beat computed with carry-in = req_cin[grant].
  - If req_last=1: stay in IDLE and set rr_ptr = grant+1 mod NUM_REQ.
  - Else: go to BURST with owner=grant.
- **State BURST:**
  - Only the owner may be readied: req_ready[owner] = req_valid[owner] & slot_free.
  - Carry-in = chain carry, i.e. the rsp_cout of the owner's previous beat. req_cin is ignored.
  - Other requesters stall regardless of their valid.
  - Accepting a last=1 beat returns to IDLE with rr_ptr = owner+1.
  - Owner valid low means wait indefinitely; the lock is held and there is no timeout.
- **Accept and capture:**
  - Accept = req_valid[g] & req_ready[g].
  - On accept, next cycle:
    - rsp_valid=1.
    - {rsp_cout, rsp_sum} = a + b + cin, full WIDTH+1-bit result.
    - rsp_id=g, rsp_last=req_last[g].
    - Chain carry is updated to the same cout.
  - Latency is exactly 1 cycle from accept to rsp_valid.
- **Response handshake:**
  - rsp_valid & rsp_ready with no accept in the same cycle: rsp_valid drops to 0.
  - Handshake plus accept in the same cycle: the register reloads, giving full throughput of 1 beat/cycle.
  - rsp_valid & !rsp_ready: response fields are held stable and no accept occurs.
- **Arithmetic:** sum wraps modulo 2^WIDTH. cout is the true bit WIDTH, not bit WIDTH-1.
- **Requester rules:**
  - A requester must hold valid, operands and last stable until ready.
  - req_valid for an index that is not granted has no effect.
- **Reset mid-burst:** burst aborts; state, ownership, chain carry and rr_ptr all clear; any pending response is dropped.

Optional Feature:
- Macro: ADDER_SHARE_ARB_OVF_EN.
- **Defined:**
  - Adds output port rsp_ovf (1 bit, reset 0), registered alongside rsp_sum.
  - rsp_ovf = signed two's-complement overflow of the beat: (a[MSB]==b[MSB]) & (sum[MSB]!=a[MSB]).
  - It is meaningful for the final word of a burst.
- **Undefined:** port absent; no other change.

Decomposition:
- **Package adder_share_pkg:**
  - Typedef arb_state_t {IDLE, BURST}.
  - Function rr_pick(valid, ptr) returning the grant index.
  - ID width helper function.
- **Sub-module adder_share_dp:**
  - Purely combinational WIDTH-bit adder returning {cout, sum}.
  - Instantiated once; the arbiter muxes operands into it.

Test Plan:
- NUM_REQ=4, req 0..3 all valid, single-beat, rsp_ready=1 -> grants in order 0,1,2,3,0; one response per cycle after 1-cycle latency; rsp_id matches.
- Req1 burst of 2 beats: first beat a=FFFFFFFF, b=1, cin=0; second beat a=0, b=0, last=1. Req2 valid throughout -> rsp_sum 00000000/cout=1, then 00000001/cout=0. Req2 is granted only after the last beat.
- rsp_ready=0 for 3 cycles while response a=5, b=7 is pending -> rsp_sum=12 held stable, all req_ready=0; resumes when rsp_ready=1.
- a=FFFFFFFF, b=FFFFFFFF, cin=1 -> rsp_sum=FFFFFFFF, rsp_cout=1. With ADDER_SHARE_ARB_OVF_EN: a=7FFFFFFF, b=1 -> rsp_ovf=1.
- Assert rst mid-burst (owner=3) -> next cycle rsp_valid=0, state IDLE, rr_ptr=0; req0 is then granted first and uses its own req_cin.
- Owner drops valid for 5 cycles mid-burst while others are valid -> no grants to others, and the chained carry is preserved on resume.
